// File: rtl/req_delay_prog.sv
// Programmable request delay line: each transition on inR is queued with a release
// timestamp and replayed on outR when the free-running cycle counter reaches it.
module req_delay_prog #(
    parameter int CNT_W       = 8,
    parameter int DEPTH       = 4,
    parameter int DEFAULT_DLY = 10,
    parameter int FOUR_PHASE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inR,
    input  logic [CNT_W-1:0] dly_val,
    input  logic             dly_load,
    output logic             outR,
    output logic             busy,
    output logic             overflow
);

    localparam int TW = CNT_W + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [TW-1:0] rel;
        logic          pol;
    } entryT;

    entryT            fifo [DEPTH];
    logic [PW-1:0]    rdPtr, wrPtr;
    logic [CW-1:0]    count, countNext;
    logic [TW-1:0]    tnow, lastRel;
    logic [TW-1:0]    dEff, relCand, relChain, relNew;
    logic [CNT_W-1:0] dly;
    logic             inRq, ev, full, pop, push, drop;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        ev   = inR ^ inRq;
        dEff = (dly == '0) ? TW'(1) : TW'(dly);
        if (FOUR_PHASE != 0 && !inR)
            dEff = TW'(1);
        relCand  = tnow + dEff;
        relChain = lastRel + TW'(1);
        // lastRel is only meaningful while entries are pending; once drained it may be
        // stale enough that the modulo compare would misjudge it.
        relNew = relCand;
        if (count != '0 && $signed(TW'(relCand - relChain)) < 0)
            relNew = relChain;
        full      = (count == CW'(DEPTH));
        pop       = (count != '0) && (fifo[rdPtr].rel == tnow);
        push      = ev && (!full || pop);
        drop      = ev && full && !pop;
        countNext = count + CW'(push) - CW'(pop);
    end

    // Storage needs no reset: occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (!rst && push)
            fifo[wrPtr] <= '{rel: relNew, pol: inR};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tnow     <= '0;
            lastRel  <= '0;
            dly      <= CNT_W'(DEFAULT_DLY);
            inRq     <= 1'b0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            count    <= '0;
            outR     <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            tnow  <= tnow + TW'(1);
            inRq  <= inR;
            count <= countNext;
            busy  <= (countNext != '0);
            if (dly_load)
                dly <= dly_val;
            if (push) begin
                wrPtr   <= ptrInc(wrPtr);
                lastRel <= relNew;
            end
            if (pop) begin
                outR  <= fifo[rdPtr].pol;
                rdPtr <= ptrInc(rdPtr);
            end
            if (drop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_req_delay_prog.sv
// Directed bench for req_delay_prog: a 2-phase and a 4-phase instance share stimulus.
module tb_req_delay_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inR = 1'b0;
    logic [7:0] dlyVal = 8'd0;
    logic       dlyLoad = 1'b0;
    logic       outRA, busyA, ovfA;
    logic       outRB, busyB, ovfB;
    int         nChk = 0;
    int         nFail = 0;

    always #5 clk = ~clk;

    req_delay_prog #(.CNT_W(8), .DEPTH(4), .DEFAULT_DLY(10), .FOUR_PHASE(0)) dutA (
        .clk(clk), .rst(rst), .inR(inR), .dly_val(dlyVal), .dly_load(dlyLoad),
        .outR(outRA), .busy(busyA), .overflow(ovfA)
    );

    req_delay_prog #(.CNT_W(8), .DEPTH(4), .DEFAULT_DLY(10), .FOUR_PHASE(1)) dutB (
        .clk(clk), .rst(rst), .inR(inR), .dly_val(dlyVal), .dly_load(dlyLoad),
        .outR(outRB), .busy(busyB), .overflow(ovfB)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChk++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic loadDly(input logic [7:0] v);
        dlyVal  = v;
        dlyLoad = 1'b1;
        @(negedge clk);
        dlyLoad = 1'b0;
    endtask

    // Inputs are set on the negedge before edge j; outputs checked on the negedge after it.
    initial begin
        int   toggles;
        logic prev;

        repeat (2) @(negedge clk);
        chk("rst outRA", outRA, 0);
        chk("rst busyA", busyA, 0);
        chk("rst ovfA", ovfA, 0);
        chk("rst outRB", outRB, 0);
        rst = 1'b0;

        // rise on the first cycle after reset, default delay 10
        for (int j = 0; j < 12; j++) begin
            inR = 1'b1;
            @(negedge clk);
            chk($sformatf("t1 outRA j=%0d", j), outRA, (j >= 10));
            chk($sformatf("t1 busyA j=%0d", j), busyA, (j < 10));
            chk($sformatf("t1 outRB j=%0d", j), outRB, (j >= 10));
        end

        // dly=3, three back-to-back toggles keep their spacing
        loadDly(8'd3);
        for (int j = 0; j < 7; j++) begin
            inR = (j == 1);
            @(negedge clk);
            chk($sformatf("t2 outRA j=%0d", j), outRA, (j < 3) || (j == 4));
            chk($sformatf("t2 outRB j=%0d", j), outRB, (j == 0) || (j == 4));
        end
        chk("t2 final outR==inR", outRA, inR);
        repeat (5) @(negedge clk);

        // dly=8, rise then fall two cycles later
        loadDly(8'd8);
        for (int j = 0; j < 13; j++) begin
            inR = (j < 2);
            @(negedge clk);
            chk($sformatf("t3 outRA j=%0d", j), outRA, (j >= 8) && (j < 10));
            chk($sformatf("t3 outRB j=%0d", j), outRB, (j == 8));
        end
        repeat (5) @(negedge clk);

        // dly=20, five toggles into a 4-deep queue
        loadDly(8'd20);
        toggles = 0;
        prev    = outRA;
        for (int j = 0; j < 28; j++) begin
            inR = (j >= 4) ? 1'b1 : (j % 2 == 0);
            @(negedge clk);
            chk($sformatf("t4 outRA j=%0d", j), outRA, (j == 20) || (j == 22));
            chk($sformatf("t4 ovfA j=%0d", j), ovfA, (j >= 4));
            if (outRA != prev) toggles++;
            prev = outRA;
        end
        chk("t4 toggles", toggles, 4);
        chk("t4 ovfB", ovfB, 1);

        rst = 1'b1;
        inR = 1'b0;
        @(negedge clk);
        chk("rst2 ovfA", ovfA, 0);
        chk("rst2 outRA", outRA, 0);
        chk("rst2 busyA", busyA, 0);
        rst = 1'b0;

        // dly=4: queue full exactly when head releases and a new edge arrives
        loadDly(8'd4);
        for (int j = 0; j < 11; j++) begin
            inR = (j >= 4) ? 1'b1 : (j % 2 == 0);
            @(negedge clk);
            chk($sformatf("t5 outRA j=%0d", j), outRA,
                (j < 4) ? 0 : (j >= 8) ? 1 : (j % 2 == 0));
            chk($sformatf("t5 ovfA j=%0d", j), ovfA, 0);
        end
        repeat (3) @(negedge clk);

        // reset with three entries pending discards them
        loadDly(8'd10);
        for (int j = 0; j < 3; j++) begin
            inR = (j == 1);
            @(negedge clk);
            chk($sformatf("t6 hold outRA j=%0d", j), outRA, 1);
        end
        rst = 1'b1;
        inR = 1'b0;
        @(negedge clk);
        chk("t6 rst outRA", outRA, 0);
        chk("t6 rst busyA", busyA, 0);
        chk("t6 rst outRB", outRB, 0);
        chk("t6 rst busyB", busyB, 0);
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            chk($sformatf("t6 quiet outRA j=%0d", j), outRA, 0);
            chk($sformatf("t6 quiet busyA j=%0d", j), busyA, 0);
        end

        // dly=0 behaves as 1
        loadDly(8'd0);
        inR = 1'b1;
        @(negedge clk);
        chk("t6 d0 outRA e0", outRA, 0);
        chk("t6 d0 outRB e0", outRB, 0);
        @(negedge clk);
        chk("t6 d0 outRA e1", outRA, 1);
        chk("t6 d0 outRB e1", outRB, 1);

        // load and edge in the same cycle: that edge uses the old delay
        dlyVal  = 8'd5;
        dlyLoad = 1'b1;
        inR     = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk($sformatf("t7 outRA j=%0d", j), outRA, (j == 0) || (j >= 6));
            chk($sformatf("t7 outRB j=%0d", j), outRB, (j == 0) || (j >= 6));
            dlyLoad = 1'b0;
            inR     = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
